// File: rtl/ahb_lite_interconnect_pkg.sv
// Shared AHB-lite encodings, data-phase FSM states and error-cause codes
// for the single-master interconnect.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    DP_NONE  = 2'b00,
    DP_SLAVE = 2'b01,
    DP_ERR1  = 2'b10,
    DP_ERR2  = 2'b11
  } dp_state_e;

  localparam logic [1:0] CAUSE_DECODE  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in ERROR responder: drives the two-cycle ERROR handshake while the
// data phase sits in DP_ERR1/DP_ERR2 and holds the software-visible error record.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  dp_state_e         state,
  input  logic              capture,
  input  logic [1:0]        cap_cause,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic              err_clr,
  output logic              ds_hready,
  output logic [1:0]        ds_hresp,
  output logic              err_valid,
  output logic [1:0]        err_cause,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_irq
);

  // First ERROR cycle stalls the master, second one completes the transfer.
  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    if (state == DP_ERR1) begin
      ds_hready = 1'b0;
      ds_hresp  = HRESP_ERROR;
    end else if (state == DP_ERR2) begin
      ds_hresp  = HRESP_ERROR;
    end
  end

  // A capture in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_cause <= '0;
      err_addr  <= '0;
      err_irq   <= 1'b0;
    end else begin
      err_irq <= capture;
      if (capture) begin
        err_valid <= 1'b1;
        err_cause <= cap_cause;
        err_addr  <= cap_addr;
      end else if (err_clr) begin
        err_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-lite interconnect: address decode, registered data-phase
// select, return mux and hung-slave timeout feeding the built-in ERROR responder.
module ahb_lite_interconnect
  import ahb_pkg::*;
#(
  parameter int                            NUM_SLAVES     = 4,
  parameter int                            ADDR_W         = 32,
  parameter int                            DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK     = '0,
  parameter int                            TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            m_haddr,
  input  logic [1:0]                   m_htrans,
  input  logic                         m_hwrite,
  input  logic [2:0]                   m_hsize,
  input  logic [2:0]                   m_hburst,
  input  logic [DATA_W-1:0]            m_hwdata,
  output logic [DATA_W-1:0]            m_hrdata,
  output logic                         m_hready,
  output logic [1:0]                   m_hresp,
  output logic [NUM_SLAVES-1:0]        s_hsel,
  output logic [ADDR_W-1:0]            s_haddr,
  output logic [1:0]                   s_htrans,
  output logic                         s_hwrite,
  output logic [2:0]                   s_hsize,
  output logic [2:0]                   s_hburst,
  output logic [DATA_W-1:0]            s_hwdata,
  output logic                         s_hready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_hrdata,
  input  logic [NUM_SLAVES-1:0]        s_hreadyout,
  input  logic [NUM_SLAVES*2-1:0]      s_hresp,
  output logic                         err_valid,
  output logic [1:0]                   err_cause,
  output logic [ADDR_W-1:0]            err_addr,
  input  logic                         err_clr,
  output logic                         err_irq
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  dp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  dsel, hit_idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] dp_addr;
  logic              hit, accept, slave_rdy, timeout, capture;
  logic [1:0]        cap_cause;
  logic [ADDR_W-1:0] cap_addr;
  logic              ds_hready;
  logic [1:0]        ds_hresp;

  assign s_haddr  = m_haddr;
  assign s_htrans = m_htrans;
  assign s_hwrite = m_hwrite;
  assign s_hsize  = m_hsize;
  assign s_hburst = m_hburst;
  assign s_hwdata = m_hwdata;
  assign s_hready = m_hready;

  // Address phase: descending scan so the lowest matching region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_haddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    s_hsel = '0;
    if (hit && m_htrans[1]) s_hsel[hit_idx] = 1'b1;
  end

  assign accept    = m_hready & m_htrans[1];
  assign slave_rdy = s_hreadyout[dsel];
  assign timeout   = (TIMEOUT_CYCLES != 0) && (state_q == DP_SLAVE) && !slave_rdy &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign capture   = (accept && !hit) || timeout;
  assign cap_cause = timeout ? CAUSE_TIMEOUT : CAUSE_DECODE;
  assign cap_addr  = timeout ? dp_addr : m_haddr;

  // Data phase: return path follows the registered select.
  always_comb begin
    m_hrdata = '0;
    m_hready = ds_hready;
    m_hresp  = ds_hresp;
    if (state_q == DP_SLAVE) begin
      m_hrdata = s_hrdata[dsel*DATA_W +: DATA_W];
      m_hready = slave_rdy;
      m_hresp  = s_hresp[dsel*2 +: 2];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DP_SLAVE: begin
        if (timeout)        state_d = DP_ERR1;
        else if (slave_rdy) state_d = DP_NONE;
      end
      DP_ERR1: state_d = DP_ERR2;
      default: state_d = DP_NONE;
    endcase
    if (accept) state_d = hit ? DP_SLAVE : DP_ERR1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DP_NONE;
      dsel     <= '0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept && hit) dsel <= hit_idx;
      if (m_hready)                                wait_cnt <= '0;
      else if (state_q == DP_SLAVE && !slave_rdy)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) dp_addr <= m_haddr;
  end

  ahb_default_slave #(.ADDR_W(ADDR_W)) u_default_slave (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state_q),
    .capture   (capture),
    .cap_cause (cap_cause),
    .cap_addr  (cap_addr),
    .err_clr   (err_clr),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .err_valid (err_valid),
    .err_cause (err_cause),
    .err_addr  (err_addr),
    .err_irq   (err_irq)
  );

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Scoreboard bench for ahb_lite_interconnect: stimulus queues expected data-phase
// responses, a negedge monitor retires them as the master sees hready.
module tb_ahb_lite_interconnect;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m_haddr;
  logic [1:0]    m_htrans;
  logic          m_hwrite;
  logic [2:0]    m_hsize, m_hburst;
  logic [DW-1:0] m_hwdata;
  logic [DW-1:0] m_hrdata;
  logic          m_hready;
  logic [1:0]    m_hresp;
  logic [NS-1:0] s_hsel;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic          s_hwrite;
  logic [2:0]    s_hsize, s_hburst;
  logic [DW-1:0] s_hwdata;
  logic          s_hready;
  logic [NS*DW-1:0] s_hrdata;
  logic [NS-1:0]    s_hreadyout;
  logic [NS*2-1:0]  s_hresp;
  logic          err_valid;
  logic [1:0]    err_cause;
  logic [AW-1:0] err_addr;
  logic          err_clr;
  logic          err_irq;

  always #5 clk = ~clk;

  ahb_lite_interconnect #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .SLAVE_BASE     ({32'h5000_0000, 32'h4000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({4{32'hF000_0000}}),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .m_haddr (m_haddr), .m_htrans (m_htrans), .m_hwrite (m_hwrite),
    .m_hsize (m_hsize), .m_hburst (m_hburst), .m_hwdata (m_hwdata),
    .m_hrdata (m_hrdata), .m_hready (m_hready), .m_hresp (m_hresp),
    .s_hsel (s_hsel), .s_haddr (s_haddr), .s_htrans (s_htrans), .s_hwrite (s_hwrite),
    .s_hsize (s_hsize), .s_hburst (s_hburst), .s_hwdata (s_hwdata), .s_hready (s_hready),
    .s_hrdata (s_hrdata), .s_hreadyout (s_hreadyout), .s_hresp (s_hresp),
    .err_valid (err_valid), .err_cause (err_cause), .err_addr (err_addr),
    .err_clr (err_clr), .err_irq (err_irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
    bit          chk_rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   pending  = 1'b0;
  int   wcnt     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr);
    m_htrans = tr;
    m_haddr  = a;
    m_hwrite = wr;
  endtask

  task automatic expect_dp(input logic [31:0] rd, input logic [1:0] rsp, input int w, input bit c);
    exp_t x;
    x.rdata = rd; x.resp = rsp; x.waits = w; x.chk_rdata = c;
    exp_q.push_back(x);
  endtask

  // Monitor: retires one expectation per completed data phase.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (pending && exp_q.size() > 0) void'(exp_q.pop_front());
      pending = 1'b0;
      wcnt    = 0;
    end else begin
      if (pending) begin
        if (m_hready) begin
          if (exp_q.size() == 0) fail_now("unexpected_completion");
          else begin
            e = exp_q.pop_front();
            chk("dp_resp", m_hresp, e.resp);
            chk("dp_waits", wcnt, e.waits);
            if (e.chk_rdata) chk("dp_rdata", m_hrdata, e.rdata);
          end
          pending = 1'b0;
        end else begin
          wcnt++;
          if (wcnt > 64) begin
            fail_now("dp_stuck");
            pending = 1'b0;
          end
        end
      end
      if (m_hready && m_htrans[1]) begin
        pending = 1'b1;
        wcnt    = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; err_clr = 1'b0;
    drive(2'b00, 32'h0, 1'b0);
    m_hsize = 3'b010; m_hburst = 3'b000; m_hwdata = '0;
    s_hreadyout = 4'hF; s_hresp = '0;
    s_hrdata = {32'h3333_3333, 32'hCAFE_0001, 32'h1111_1111, 32'h0000_A000};
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_hready", m_hready, 1);
    chk("rst_hresp", m_hresp, 0);
    chk("rst_hrdata", m_hrdata, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_cause", err_cause, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_irq", err_irq, 0);
    chk("rst_hsel", s_hsel, 0);

    // Single read from slave 2
    tick(); drive(2'b10, 32'h4000_0010, 1'b0); expect_dp(32'hCAFE_0001, 2'b00, 0, 1'b1);
    #1; chk("rd2_hsel", s_hsel, 4'b0100); chk("rd2_haddr", s_haddr, 32'h4000_0010);
    tick(); drive(2'b01, 32'h4000_0000, 1'b0);
    #1; chk("busy_hsel", s_hsel, 0);

    // Pipelined write to slave 0 then read from slave 3
    tick(); drive(2'b10, 32'h0000_0100, 1'b1); expect_dp(32'h0, 2'b00, 0, 1'b0);
    #1; chk("wr0_hsel", s_hsel, 4'b0001);
    tick(); drive(2'b10, 32'h5000_0020, 1'b0); m_hwdata = 32'hDEAD_BEEF;
    expect_dp(32'h3333_3333, 2'b00, 0, 1'b1);
    #1; chk("rd3_hsel", s_hsel, 4'b1000); chk("wr0_hwdata", s_hwdata, 32'hDEAD_BEEF);
    chk("wr0_hready", m_hready, 1);
    tick(); drive(2'b00, 32'h0, 1'b0);

    // Slave 0 with two wait states
    tick(); drive(2'b10, 32'h0000_0200, 1'b0); s_hreadyout[0] = 1'b0;
    expect_dp(32'h0000_A000, 2'b00, 2, 1'b1);
    tick(); drive(2'b00, 32'h0, 1'b0);
    #1; chk("ws_hready", m_hready, 0);
    tick();
    tick(); s_hreadyout[0] = 1'b1;

    // Decode miss
    tick(); drive(2'b10, 32'hF000_0000, 1'b0); expect_dp(32'h0, 2'b01, 1, 1'b1);
    #1; chk("miss_hsel", s_hsel, 0);
    tick(); drive(2'b00, 32'h0, 1'b0);
    #1; chk("miss_e1_hready", m_hready, 0); chk("miss_e1_hresp", m_hresp, 2'b01);
    chk("miss_irq", err_irq, 1); chk("miss_valid", err_valid, 1);
    chk("miss_cause", err_cause, 2'b01); chk("miss_addr", err_addr, 32'hF000_0000);
    tick();
    #1; chk("miss_e2_hready", m_hready, 1); chk("miss_e2_hresp", m_hresp, 2'b01);
    chk("miss_irq_pulse", err_irq, 0); chk("miss_e2_rdata", m_hrdata, 0);

    // err_clr alone clears only the valid flag
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    #1; chk("clr_valid", err_valid, 0); chk("clr_cause_kept", err_cause, 2'b01);
    chk("clr_addr_kept", err_addr, 32'hF000_0000);

    // Hung slave 1
    tick(); drive(2'b10, 32'h1000_0040, 1'b0); s_hreadyout[1] = 1'b0;
    expect_dp(32'h0, 2'b01, TO + 1, 1'b1);
    #1; chk("to_hsel", s_hsel, 4'b0010);
    tick(); drive(2'b00, 32'h0, 1'b0);
    repeat (TO - 1) tick();
    #1; chk("to_last_stall", m_hready, 0); chk("to_no_irq_yet", err_irq, 0);
    tick();
    #1; chk("to_e1_hresp", m_hresp, 2'b01); chk("to_cause", err_cause, 2'b10);
    chk("to_addr", err_addr, 32'h1000_0040); chk("to_irq", err_irq, 1);
    tick();
    #1; chk("to_e2_hready", m_hready, 1); chk("to_e2_s_hready", s_hready, 1);
    tick(); s_hresp[3:2] = 2'b01;
    #1; chk("to_ignored_hready", m_hready, 1); chk("to_ignored_hresp", m_hresp, 0);
    s_hreadyout[1] = 1'b1; s_hresp = '0;

    // Capture beats err_clr in the same cycle
    tick(); drive(2'b10, 32'hE000_0000, 1'b0); err_clr = 1'b1;
    expect_dp(32'h0, 2'b01, 1, 1'b1);
    tick(); drive(2'b00, 32'h0, 1'b0); err_clr = 1'b0;
    #1; chk("race_valid", err_valid, 1); chk("race_addr", err_addr, 32'hE000_0000);
    chk("race_cause", err_cause, 2'b01);
    tick();

    // Reset during DP_ERR1
    tick(); drive(2'b10, 32'hF000_0004, 1'b0); expect_dp(32'h0, 2'b01, 1, 1'b1);
    tick(); drive(2'b00, 32'h0, 1'b0); rst_n = 1'b0;
    #1; chk("rstmid_in_err1", m_hready, 0);
    tick(); rst_n = 1'b1;
    #1; chk("rstmid_hready", m_hready, 1); chk("rstmid_hresp", m_hresp, 0);
    chk("rstmid_valid", err_valid, 0); chk("rstmid_addr", err_addr, 0);
    chk("rstmid_irq", err_irq, 0); chk("rstmid_rdata", m_hrdata, 0);

    // Recovery transfer
    tick(); drive(2'b10, 32'h5000_0000, 1'b0); expect_dp(32'h3333_3333, 2'b00, 0, 1'b1);
    tick(); drive(2'b00, 32'h0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_interconnect.md
# ahb_lite_interconnect

Parametrised single-master AHB-lite interconnect that replaces the fixed four-slave bus between the CPU/DMA master port and the peripheral slaves. It decodes a configurable address map onto `NUM_SLAVES` slaves and tracks the data phase with a registered select, so read data and responses are muxed from the correct slave. Unmapped transfers and hung slaves are answered by a built-in two-cycle ERROR responder. The block captures the failing address for software.

## Interface
- `NUM_SLAVES`, 4: number of slave ports (1..16).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width (32 or 64).
- `SLAVE_BASE`, `{NUM_SLAVES{ADDR_W'h0}}`: packed array of region base addresses.
- `SLAVE_MASK`, `{NUM_SLAVES{ADDR_W'h0}}`: packed array of region masks; slave i matches when `(m_haddr & SLAVE_MASK[i]) == SLAVE_BASE[i]`.
- `TIMEOUT_CYCLES`, 256: number of wait cycles before a slave is declared hung; 0 disables the timeout.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `m_haddr` in ADDR_W: master address.
- `m_htrans` in 2: master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- `m_hwrite`, `m_hsize[2:0]`, `m_hburst[2:0]`, `m_hwdata[DATA_W]` in: master controls and write data.
- `m_hrdata` out DATA_W: read data returned to the master.
- `m_hready` out 1: transfer-complete signal to the master.
- `m_hresp` out 2: response to the master (OKAY=00, ERROR=01).
- `s_hsel` out NUM_SLAVES: one-hot slave select, address phase.
- `s_haddr`, `s_htrans`, `s_hwrite`, `s_hsize`, `s_hburst`, `s_hwdata` out: master signals broadcast unchanged to all slaves.
- `s_hready` out 1: broadcast copy of `m_hready`.
- `s_hrdata` in NUM_SLAVES×DATA_W, `s_hreadyout` in NUM_SLAVES, `s_hresp` in NUM_SLAVES×2: per-slave return signals.
- `err_valid` out 1: sticky error flag.
- `err_cause` out 2: error cause (01 = decode miss, 10 = timeout).
- `err_addr` out ADDR_W: captured address of the failing transfer.
- `err_clr` in 1: one-cycle pulse that clears `err_valid`.
- `err_irq` out 1: one-cycle pulse when an error is captured.

## Operation
- An address phase is accepted when `m_hready=1` and `m_htrans[1]=1`.
- Decode runs every cycle. `s_hsel[i]` is asserted for the lowest-index matching region and is gated by `m_htrans[1]`. BUSY and IDLE transfers drive `s_hsel=0`.
- On an accepted address phase:
  - A matched transfer registers the slave index into `dsel` and the FSM enters DP_SLAVE.
  - A decode miss enters DP_ERR1 and latches the address.
- FSM states (package enum): DP_NONE, DP_SLAVE, DP_ERR1, DP_ERR2.
  - DP_NONE: `m_hready=1`, `m_hresp=OKAY`.
  - DP_SLAVE: `m_hrdata`, `m_hready` and `m_hresp` are taken from slave `dsel`. When `m_hready=1`, the next state is chosen by the new address phase (DP_SLAVE, DP_ERR1 or DP_NONE).
  - DP_ERR1: `m_hready=0`, `m_hresp=ERROR`; always advances to DP_ERR2.
  - DP_ERR2: `m_hready=1`, `m_hresp=ERROR`; the address phase presented in this cycle is accepted normally.
- Timeout: `wait_cnt` (width `$clog2(TIMEOUT_CYCLES+1)`) increments in DP_SLAVE while `s_hreadyout[dsel]=0`. It resets to 0 whenever `m_hready=1`.
  - When `wait_cnt == TIMEOUT_CYCLES-1` with the slave still stalled, the next state is DP_ERR1 with cause 10.
  - After a timeout, the slave's later `hreadyout` and `hresp` are ignored.
  - The slave sees `s_hready=1` during DP_ERR2. This is accepted as completion of its transfer.
- Error capture:
  - On entry to DP_ERR1, `err_addr` is loaded with the data-phase address, `err_cause` is set, `err_valid` is set and `err_irq` pulses once.
  - A new error overwrites the captured fields even if `err_valid` is already 1.
  - `err_clr` clears `err_valid` only. If a capture happens in the same cycle as `err_clr`, the capture wins.
- `m_hrdata` is 0 in DP_NONE, DP_ERR1 and DP_ERR2.

## Timing
- Reset values: state DP_NONE, `dsel=0`, `wait_cnt=0`, `m_hready=1`, `m_hresp=00`, `m_hrdata=0`, `err_valid=0`, `err_cause=0`, `err_addr=0`, `err_irq=0`.
- Latency:
  - Decode and `s_hsel` are combinational, with zero added cycles.
  - Read data and response are combinational from the `dsel` register.
  - A zero-wait slave completes in 1 data-phase cycle.
  - A decode miss completes in exactly 2 cycles.
  - A timeout gives the master `m_hready=1` exactly `TIMEOUT_CYCLES+2` cycles after the data phase starts.
- Reset asserted mid-transfer aborts the data phase. In the next cycle all outputs are at their reset values and there is no error capture.
- Back-to-back pipelined transfers across different slaves run at full rate with no bubbles.

## Structure
- `ahb_pkg` holds:
  - the `htrans_e` and `hresp_e` definitions;
  - the `dp_state_e` FSM enum;
  - the error-cause constants.
- Sub-module `ahb_default_slave` implements the DP_ERR1/DP_ERR2 two-cycle ERROR sequence and the error capture registers.
- The top level holds the decoder, the `dsel` register, the return mux and the timeout counter.

## Test plan
- Slave 2 mapped at base 0x4000_0000, mask 0xF000_0000; NONSEQ read of 0x4000_0010 with slave 2 returning 0xCAFE_0001 -> `s_hsel=0100`; next cycle `m_hrdata=0xCAFE_0001`, `m_hresp=OKAY`.
- Pipelined write to slave 0 followed by a read from slave 3 with zero waits -> two data phases in consecutive cycles; read data comes from slave 3 and is not corrupted by slave 0.
- NONSEQ to unmapped 0xF000_0000 -> `m_hready` goes 0 then 1 with `m_hresp=ERROR` in both cycles; `err_addr=0xF000_0000`, `err_cause=01`, `err_irq` high for 1 cycle.
- `TIMEOUT_CYCLES=8`, slave 1 holds `hreadyout=0` indefinitely -> ERROR completes at data-phase cycle 10; `err_cause=10`; later `hreadyout` from slave 1 is ignored.
- `err_clr` pulsed in the same cycle as a new decode-miss capture -> `err_valid` stays 1 with the new address.
- `rst_n` driven low during DP_ERR1 -> next cycle `m_hready=1`, `m_hresp=OKAY`, `err_valid=0`.
